// File: rtl/synth_pkg.sv
// synth_pkg: shared types and helpers for the synth_voice_bank slice.
//   wave_t   - per-voice waveform select (matches the 2-bit cfg_wave encoding)
//   state_t  - sample-assembly FSM state
//   calc_div - system clocks per sample period (integer truncation)
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_OFF    = 2'b11
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/synth_wave_gen.sv
// synth_wave_gen: combinational waveform lookup shared by all voices.
//   wave - waveform select
//   p    - top SAMPLE_W bits of the voice phase (unsigned)
//   y    - signed sample in [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]
module synth_wave_gen
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 24
) (
  input  wave_t                      wave,
  input  logic        [SAMPLE_W-1:0] p,
  output logic signed [SAMPLE_W-1:0] y
);

  logic [SAMPLE_W-2:0] u;
  logic [SAMPLE_W-1:0] tri_raw;

  // Folding the lower phase bits on the MSB gives a rising/falling ramp;
  // subtracting M from an unsigned value is just an MSB flip.
  always_comb begin
    u       = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
    tri_raw = {u, 1'b0};
    y       = '0;
    unique case (wave)
      WAVE_SQUARE: y = p[SAMPLE_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                     : {1'b0, {(SAMPLE_W-1){1'b1}}};
      WAVE_SAW:    y = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
      WAVE_TRI:    y = {~tri_raw[SAMPLE_W-1], tri_raw[SAMPLE_W-2:0]};
      WAVE_OFF:    y = '0;
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/synth_voice_bank.sv
// synth_voice_bank: NUM_VOICES phase-accumulator oscillators sharing one
// waveform/accumulate datapath, mixed into one signed sample per sample
// period and delivered over a valid/ready handshake.
// Build option: SYNTH_MIX_SAT_EN defined -> full-level sum saturated to the
// sample range; undefined -> sum averaged (>>> log2(NUM_VOICES)).
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   cfg_we/cfg_voice      voice config write strobe and voice index
//   cfg_inc/cfg_wave/cfg_en  phase increment, waveform, enable (en=0 clears phase)
//   sample/sample_valid/sample_ready  mixed output handshake
//   overrun/overrun_clr   sticky dropped-tick flag and its clear
module synth_voice_bank
  import synth_pkg::*;
#(
  parameter  int NUM_VOICES = 4,
  parameter  int SAMPLE_W   = 24,
  parameter  int PHASE_W    = 24,
  parameter  int CLK_HZ     = 50_000_000,
  parameter  int SAMPLE_HZ  = 44_100,
  localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_we,
  input  logic        [VW-1:0]       cfg_voice,
  input  logic        [PHASE_W-1:0]  cfg_inc,
  input  logic        [1:0]          cfg_wave,
  input  logic                       cfg_en,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int DIV  = int'(calc_div(CLK_HZ, SAMPLE_HZ));
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LOGN = $clog2(NUM_VOICES);
  localparam int AW   = SAMPLE_W + LOGN;

  logic [PHASE_W-1:0]      phase [NUM_VOICES];
  logic [PHASE_W-1:0]      inc   [NUM_VOICES];
  wave_t                   wave_r[NUM_VOICES];
  logic [NUM_VOICES-1:0]   en;

  logic [CW-1:0]           tick_cnt;
  logic                    tick;
  state_t                  state;
  logic [VW-1:0]           v;
  logic signed [AW-1:0]    acc;
  logic signed [SAMPLE_W-1:0] wave_y;
  logic signed [SAMPLE_W-1:0] mix;

  assign tick = (tick_cnt == CW'(DIV - 1));

  synth_wave_gen #(
    .SAMPLE_W(SAMPLE_W)
  ) u_wave_gen (
    .wave(wave_r[v]),
    .p   (phase[v][PHASE_W-1 -: SAMPLE_W]),
    .y   (wave_y)
  );

`ifdef SYNTH_MIX_SAT_EN
  localparam logic signed [AW-1:0] SAT_HI = AW'({1'b0, {(SAMPLE_W-1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    mix = SAMPLE_W'(acc);
    if (acc > SAT_HI)
      mix = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (acc < SAT_LO)
      mix = {1'b1, {(SAMPLE_W-1){1'b0}}};
  end
`else
  always_comb begin
    mix = SAMPLE_W'(acc >>> LOGN);
  end
`endif

  // Voice registers. A disabling write wins over the voice's own phase
  // advance when both land on the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        phase[i]  <= '0;
        inc[i]    <= '0;
        wave_r[i] <= WAVE_SQUARE;
        en[i]     <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (cfg_we && (cfg_voice == VW'(i))) begin
          inc[i]    <= cfg_inc;
          wave_r[i] <= wave_t'(cfg_wave);
          en[i]     <= cfg_en;
        end
        if (cfg_we && (cfg_voice == VW'(i)) && !cfg_en)
          phase[i] <= '0;
        else if ((state == ST_ACCUM) && (v == VW'(i)) && en[i])
          phase[i] <= phase[i] + inc[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt     <= '0;
      state        <= ST_IDLE;
      v            <= '0;
      acc          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

      if (overrun_clr)
        overrun <= 1'b0;
      else if (tick && sample_valid)
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (tick && !sample_valid) begin
            state <= ST_ACCUM;
            acc   <= '0;
            v     <= '0;
          end
        end
        ST_ACCUM: begin
          if (en[v])
            acc <= acc + AW'(wave_y);
          if (v == VW'(NUM_VOICES - 1))
            state <= ST_SCALE;
          else
            v <= v + VW'(1);
        end
        ST_SCALE: begin
          sample       <= mix;
          sample_valid <= 1'b1;
          state        <= ST_HOLD;
        end
        ST_HOLD: begin
          if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_voice_bank.sv
`timescale 1ns/1ps
module tb_synth_voice_bank;

  localparam int NV = 4;
  localparam int SW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_voice = '0;
  logic [PW-1:0] cfg_inc = '0;
  logic [1:0]    cfg_wave = '0;
  logic          cfg_en = 1'b0;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready = 1'b1;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc;

  typedef struct {
    int val;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  synth_voice_bank #(
    .NUM_VOICES(NV),
    .SAMPLE_W  (SW),
    .PHASE_W   (PW),
    .CLK_HZ    (1000),
    .SAMPLE_HZ (100)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_voice   (cfg_voice),
    .cfg_inc     (cfg_inc),
    .cfg_wave    (cfg_wave),
    .cfg_en      (cfg_en),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  // cyc = clock edges since reset release; at a negedge it names the cycle.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  function automatic int ssmp(input logic [SW-1:0] s);
    return int'($signed(s));
  endfunction

  // Expected mix of a hand-computed voice sum.
  function automatic int mixf(input int s);
`ifdef SYNTH_MIX_SAT_EN
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return s;
`else
    return s >>> 2;
`endif
  endfunction

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int val, input int c);
    exp_t e;
    e.val = val;
    e.cyc = c;
    q.push_back(e);
  endtask

  // Monitor: every accepted sample must match the head of the scoreboard.
  always @(negedge clk) begin
    #1;
    if (reset_n && sample_valid && sample_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected sample: got %0d at cycle %0d, required none", ssmp(sample), cyc);
      end else begin
        mon_e = q.pop_front();
        check("sample value", ssmp(sample), mon_e.val);
        if (mon_e.cyc >= 0) check("sample cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    cfg_we      = 1'b0;
    overrun_clr = 1'b0;
    @(negedge clk);
    check("reset sample", ssmp(sample), 0);
    check("reset valid", int'(sample_valid), 0);
    check("reset overrun", int'(overrun), 0);
    @(negedge clk);
    q.delete();
    reset_n = 1'b1;
  endtask

  task automatic cfg(input int v, input int inc, input int w, input bit en);
    cfg_we    = 1'b1;
    cfg_voice = 2'(v);
    cfg_inc   = 8'(inc);
    cfg_wave  = 2'(w);
    cfg_en    = en;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      tests++;
      fails++;
      $display("FAIL wait_cycle: got cycle %0d, required %0d", cyc, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d samples pending, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // No voices configured: silent samples on a 10-cycle cadence from cycle 15.
    do_reset();
    push(0, 15); push(0, 25); push(0, 35);
    wait_cycle(14);
    check("no early valid", int'(sample_valid), 0);
    drain();

    // Voice 0 square, half-cycle increment: alternating full-scale levels.
    do_reset();
    cfg(0, 8'h80, 0, 1'b1);
    push(mixf(127), 15); push(mixf(-128), 25);
    push(mixf(127), 35); push(mixf(-128), 45);
    drain();

    // All four voices square at phase 0: sum 508.
    do_reset();
    for (int v = 0; v < NV; v++) cfg(v, 0, 0, 1'b1);
    push(mixf(508), 15); push(mixf(508), 25);
    drain();

    // Voice 1 saw, inc 0x10: ramp that wraps after 16 samples.
    do_reset();
    cfg(1, 8'h10, 1, 1'b1);
    for (int k = 0; k <= 16; k++) push(mixf(((16 * k) % 256) - 128), 15 + 10 * k);
    drain();

    // Backpressure: held sample, overrun set/clear priority, no phase advance.
    sample_ready = 1'b0;
    do_reset();
    cfg(0, 8'h10, 1, 1'b1);
    wait_cycle(15);
    check("held valid", int'(sample_valid), 1);
    check("held sample", ssmp(sample), mixf(-128));
    wait_cycle(19);
    check("overrun before drop", int'(overrun), 0);
    wait_cycle(20);
    check("overrun after drop", int'(overrun), 1);
    wait_cycle(29);
    overrun_clr = 1'b1;
    wait_cycle(30);
    overrun_clr = 1'b0;
    check("clr beats set", int'(overrun), 0);
    check("still held sample", ssmp(sample), mixf(-128));
    check("still held valid", int'(sample_valid), 1);
    wait_cycle(40);
    check("overrun reset by drop", int'(overrun), 1);
    push(mixf(-128), 40);
    push(mixf(-112), 55);
    sample_ready = 1'b1;
    wait_cycle(50);
    overrun_clr = 1'b1;
    wait_cycle(51);
    overrun_clr = 1'b0;
    check("overrun cleared", int'(overrun), 0);
    drain();

    // Disable voice 2 just before its slot; re-enable shows its phase cleared.
    do_reset();
    cfg(0, 8'h40, 1, 1'b1);
    cfg(2, 8'h40, 1, 1'b1);
    push(mixf(-256), 15); push(mixf(-64), 25); push(mixf(-128), 35);
    wait_cycle(21);
    cfg(2, 8'h40, 1, 1'b0);
    wait_cycle(30);
    cfg(2, 8'h40, 1, 1'b1);
    wait_cycle(41);
    check("queue empty before abort", q.size(), 0);
    reset_n = 1'b0;
    #1;
    check("abort sample", ssmp(sample), 0);
    check("abort valid", int'(sample_valid), 0);
    check("abort overrun", int'(overrun), 0);
    @(negedge clk);
    @(negedge clk);
    q.delete();
    reset_n = 1'b1;
    push(0, 15);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
